// File: rtl/sc_lsu_axil.sv
// sc_lsu_axil: load/store unit for the single-cycle core.
// Converts one decoded load/store into a single AXI4-Lite master transaction.
// The core is held with stall until the response returns. Misaligned accesses
// are rejected without touching the bus, and non-OKAY responses raise mem_err.
module sc_lsu_axil #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_uns,
    output logic                stall,
    output logic [DATA_W-1:0]   ld_data,
    output logic                ld_valid,
    output logic                mem_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB_W = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // An access is misaligned when it is wider than the bus or its byte offset
    // is not a multiple of its own size.
    function automatic logic misaligned_f(input logic [LSB_W-1:0] lsb, input logic [1:0] size);
        logic             bad;
        logic [LSB_W-1:0] mask;
        if (int'(size) > LSB_W) begin
            bad  = 1'b1;
            mask = '0;
        end else begin
            mask = LSB_W'((1 << int'(size)) - 1);
            bad  = ((lsb & mask) != '0);
        end
        return bad;
    endfunction

    // Byte-lane strobes covering 2^size bytes starting at the lane offset.
    function automatic logic [NB-1:0] strb_f(input logic [LSB_W-1:0] lsb, input logic [1:0] size);
        logic [NB-1:0] s;
        s = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(lsb)) && (i < int'(lsb) + (1 << int'(size)))) begin
                s[i] = 1'b1;
            end else begin
                s[i] = 1'b0;
            end
        end
        return s;
    endfunction

    // Replicate the right-justified store operand across every size-wide lane,
    // so the strobes alone pick the bytes that land in memory.
    function automatic logic [DATA_W-1:0] repl_f(input logic [DATA_W-1:0] d, input logic [1:0] size);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = d[8*(i % (1 << int'(size))) +: 8];
        end
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_W-1:0] extend_f(input logic [DATA_W-1:0] rd,
                                                   input logic [LSB_W-1:0]  lsb,
                                                   input logic [1:0]        size,
                                                   input logic              uns);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        logic              sign;
        int                nb;
        sh = rd >> {lsb, 3'b000};
        nb = 1 << int'(size);
        if (nb > NB) begin
            nb = NB;
        end else begin
            nb = nb;
        end
        if (uns) begin
            sign = 1'b0;
        end else begin
            sign = sh[8*nb-1];
        end
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nb) begin
                r[8*i +: 8] = sh[8*i +: 8];
            end else begin
                r[8*i +: 8] = {8{sign}};
            end
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] awaddr_r, awaddr_s;
    logic              awvalid_r, awvalid_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic [NB-1:0]     wstrb_r, wstrb_s;
    logic              wvalid_r, wvalid_s;
    logic              bready_r, bready_s;
    logic [ADDR_W-1:0] araddr_r, araddr_s;
    logic              arvalid_r, arvalid_s;
    logic              rready_r, rready_s;
    logic [DATA_W-1:0] ld_data_r, ld_data_s;
    logic              ld_valid_r, ld_valid_s;
    logic              mem_err_r, mem_err_s;
    logic [LSB_W-1:0]  lsb_r, lsb_s;
    logic [1:0]        size_r, size_s;
    logic              uns_r, uns_s;
    logic [ADDR_W-1:0] aligned_s;

    assign aligned_s = {req_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};

    // Stall the core for every cycle of a pending access except the commit cycle.
    assign stall = (req_rd | req_wr) & (state_r != ST_DONE);

    assign m_awaddr  = awaddr_r;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid_r;
    assign m_wdata   = wdata_r;
    assign m_wstrb   = wstrb_r;
    assign m_wvalid  = wvalid_r;
    assign m_bready  = bready_r;
    assign m_araddr  = araddr_r;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arvalid_r;
    assign m_rready  = rready_r;
    assign ld_data   = ld_data_r;
    assign ld_valid  = ld_valid_r;
    assign mem_err   = mem_err_r;

    // Next-state and next-output logic; result/error pulses default low so they live only in DONE.
    always_comb begin
        state_s    = state_r;
        awaddr_s   = awaddr_r;
        awvalid_s  = awvalid_r;
        wdata_s    = wdata_r;
        wstrb_s    = wstrb_r;
        wvalid_s   = wvalid_r;
        bready_s   = bready_r;
        araddr_s   = araddr_r;
        arvalid_s  = arvalid_r;
        rready_s   = rready_r;
        ld_data_s  = ld_data_r;
        ld_valid_s = 1'b0;
        mem_err_s  = 1'b0;
        lsb_s      = lsb_r;
        size_s     = size_r;
        uns_s      = uns_r;
        case (state_r)
            ST_IDLE: begin
                if (req_rd | req_wr) begin
                    lsb_s  = req_addr[LSB_W-1:0];
                    size_s = req_size;
                    uns_s  = req_uns;
                    if (misaligned_f(req_addr[LSB_W-1:0], req_size)) begin
                        mem_err_s = 1'b1;
                        state_s   = ST_DONE;
                    end else if (req_wr) begin
                        awaddr_s  = aligned_s;
                        awvalid_s = 1'b1;
                        wdata_s   = repl_f(req_wdata, req_size);
                        wstrb_s   = strb_f(req_addr[LSB_W-1:0], req_size);
                        wvalid_s  = 1'b1;
                        state_s   = ST_WR;
                    end else begin
                        araddr_s  = aligned_s;
                        arvalid_s = 1'b1;
                        state_s   = ST_RD_ADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                // Each channel drops its own valid on its own handshake.
                if (awvalid_r && m_awready) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && m_wready) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (!awvalid_s && !wvalid_s) begin
                    bready_s = 1'b1;
                    state_s  = ST_WR_RESP;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    bready_s  = 1'b0;
                    mem_err_s = (m_bresp != 2'b00);
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = ST_RD_DATA;
                end else begin
                    state_s = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rready_s   = 1'b0;
                    ld_valid_s = 1'b1;
                    if (m_rresp != 2'b00) begin
                        mem_err_s = 1'b1;
                        ld_data_s = '0;
                    end else begin
                        ld_data_s = extend_f(m_rdata, lsb_r, size_r, uns_r);
                    end
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD_DATA;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
            end
        endcase
    end

    // State and registered bus/result outputs; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            awaddr_r   <= '0;
            awvalid_r  <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            araddr_r   <= '0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            ld_data_r  <= '0;
            ld_valid_r <= 1'b0;
            mem_err_r  <= 1'b0;
            lsb_r      <= '0;
            size_r     <= 2'b00;
            uns_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            awaddr_r   <= awaddr_s;
            awvalid_r  <= awvalid_s;
            wdata_r    <= wdata_s;
            wstrb_r    <= wstrb_s;
            wvalid_r   <= wvalid_s;
            bready_r   <= bready_s;
            araddr_r   <= araddr_s;
            arvalid_r  <= arvalid_s;
            rready_r   <= rready_s;
            ld_data_r  <= ld_data_s;
            ld_valid_r <= ld_valid_s;
            mem_err_r  <= mem_err_s;
            lsb_r      <= lsb_s;
            size_r     <= size_s;
            uns_r      <= uns_s;
        end
    end

endmodule

// File: tb/tb_sc_lsu_axil.sv
// Testbench for sc_lsu_axil: AXI4-Lite slave model with programmable ready and
// response delays, plus a byte-array reference memory for expected load values.
module tb_sc_lsu_axil;

    logic        clk, rst;
    logic        req_rd, req_wr, req_uns;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        stall, ld_valid, mem_err;
    logic [31:0] ld_data;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    int checks = 0;
    int errors = 0;

    // slave controls
    int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic b_err = 1'b0, r_err = 1'b0;
    // slave state
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr, r_data_q;
    logic [3:0]  cap_wstrb;
    logic [31:0] smem [0:63] = '{default: 32'h0};
    int          valid_cycles = 0;

    // reference model
    logic [7:0]  ref_mem [0:255] = '{default: 8'h00};
    logic [2:0]  trace_q [$];

    sc_lsu_axil #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_uns(req_uns), .stall(stall),
        .ld_data(ld_data), .ld_valid(ld_valid), .mem_err(mem_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
    assign m_wready  = m_wvalid && (w_cnt >= w_dly);
    assign m_arready = m_arvalid && (ar_cnt >= ar_dly);
    assign m_bvalid  = b_pend && (b_cnt >= b_dly);
    assign m_rvalid  = r_pend && (r_cnt >= r_dly);
    assign m_bresp   = b_err ? 2'b10 : 2'b00;
    assign m_rresp   = r_err ? 2'b10 : 2'b00;
    assign m_rdata   = r_data_q;

    // Count cycles in which the master drives any valid/ready.
    always @(posedge clk) begin
        if (m_awvalid | m_wvalid | m_arvalid | m_bready | m_rready) valid_cycles <= valid_cycles + 1;
    end

    // AXI4-Lite slave model.
    always @(posedge clk) begin
        logic        aw_now, w_now;
        logic [31:0] a, d;
        logic [3:0]  s;
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            r_data_q <= 32'h0;
        end else begin
            aw_now = aw_got;
            w_now  = w_got;
            a = cap_awaddr; d = cap_wdata; s = cap_wstrb;
            if (m_awvalid && m_awready) begin
                aw_got <= 1'b1; cap_awaddr <= m_awaddr; aw_cnt <= 0;
                aw_now = 1'b1; a = m_awaddr;
            end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_wvalid && m_wready) begin
                w_got <= 1'b1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; w_cnt <= 0;
                w_now = 1'b1; d = m_wdata; s = m_wstrb;
            end else if (m_wvalid) w_cnt <= w_cnt + 1;
            if (b_pend) begin
                if (m_bvalid && m_bready) begin b_pend <= 1'b0; b_cnt <= 0; end
                else b_cnt <= b_cnt + 1;
            end else if (aw_now && w_now) begin
                if (!b_err) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) smem[a[7:2]][8*b +: 8] <= d[8*b +: 8];
                end
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (r_pend) begin
                if (m_rvalid && m_rready) begin r_pend <= 1'b0; r_cnt <= 0; end
                else r_cnt <= r_cnt + 1;
            end else if (m_arvalid && m_arready) begin
                r_pend <= 1'b1; r_cnt <= 0; r_data_q <= smem[m_araddr[7:2]];
                cap_araddr <= m_araddr; ar_cnt <= 0;
            end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
        end
    end

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        int n = 1 << size;
        return (size == 2'd3) || ((addr % n) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int     n = 1 << size;
        longint v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[(addr & 255) + k]) << (8 * k));
        if (!uns && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int n = 1 << size;
        for (int k = 0; k < n; k++) ref_mem[(addr & 255) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // Run one access to completion; returns stall length and the DONE-cycle results.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input logic uns, output int nst,
                          output logic err, output logic lv, output logic [31:0] data);
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wd; req_size = size; req_uns = uns;
        trace_q.delete();
        nst = 0;
        #1;
        while (stall && nst < 200) begin
            trace_q.push_back({m_awvalid, m_wvalid, m_bready});
            nst++;
            @(posedge clk); #1;
        end
        if (nst >= 200) begin
            checks++; errors++;
            $display("FAIL timeout: stall stuck high, got %0d cycles, need < 200", nst);
        end
        err = mem_err; lv = ld_valid; data = ld_data;
        req_rd = 1'b0; req_wr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ld_valid !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: ld_valid=%b mem_err=%b after DONE, need 0 0", ld_valid, mem_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b00; req_uns = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, ld_valid, mem_err, stall} !== 8'h00 ||
            ld_data !== 32'h0 || m_awprot !== 3'b000 || m_arprot !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: valids/flags=%b ld_data=%h, need all zero",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, ld_valid, mem_err, stall}, ld_data);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_store_word();
        int n; logic e, lv; logic [31:0] d;
        set_delays(0, 0, 0, 0, 0);
        access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, n, e, lv, d);
        ref_store(32'h100, 2'd2, 32'hDEADBEEF);
        checks++;
        if (n !== 3 || e !== 1'b0 || lv !== 1'b0) begin
            errors++; $display("FAIL sw_timing: stall=%0d err=%b lv=%b, need 3 0 0", n, e, lv);
        end
        checks++;
        if (cap_awaddr !== 32'h100 || cap_wstrb !== 4'hF || cap_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus: awaddr=%h wstrb=%h wdata=%h, need 100 f deadbeef",
                               cap_awaddr, cap_wstrb, cap_wdata);
        end
    endtask

    task automatic test_loads();
        int n; logic e, lv; logic [31:0] d;
        access(1'b0, 1'b1, 32'h100, 32'h80FF0000, 2'd2, 1'b0, n, e, lv, d);
        ref_store(32'h100, 2'd2, 32'h80FF0000);
        access(1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0, n, e, lv, d);
        checks++;
        if (d !== 32'hFFFFFF80 || lv !== 1'b1 || e !== 1'b0 || n !== 3 || cap_araddr !== 32'h100) begin
            errors++; $display("FAIL lb_signed: data=%h lv=%b err=%b stall=%0d araddr=%h, need ffffff80 1 0 3 100",
                               d, lv, e, n, cap_araddr);
        end
        access(1'b1, 1'b0, 32'h102, 32'h0, 2'd1, 1'b1, n, e, lv, d);
        checks++;
        if (d !== 32'h000080FF || lv !== 1'b1) begin
            errors++; $display("FAIL lhu: data=%h lv=%b, need 000080ff 1", d, lv);
        end
        access(1'b0, 1'b1, 32'h102, 32'h5555ABCD, 2'd1, 1'b0, n, e, lv, d);
        ref_store(32'h102, 2'd1, 32'h5555ABCD);
        checks++;
        if (cap_wdata !== 32'hABCDABCD || cap_wstrb !== 4'hC || cap_awaddr !== 32'h100) begin
            errors++; $display("FAIL sh_bus: wdata=%h wstrb=%h awaddr=%h, need abcdabcd c 100",
                               cap_wdata, cap_wstrb, cap_awaddr);
        end
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, n, e, lv, d);
        checks++;
        if (d !== 32'hABCD0000) begin
            errors++; $display("FAIL lw_after_sh: data=%h, need abcd0000", d);
        end
    endtask

    task automatic test_misaligned();
        int n, v0; logic e, lv; logic [31:0] d;
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h000};
        logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            v0 = valid_cycles;
            access(i[0], !i[0], addrs[i], 32'h12345678, sizes[i], 1'b0, n, e, lv, d);
            checks++;
            if (e !== 1'b1 || n !== 1 || valid_cycles !== v0) begin
                errors++; $display("FAIL misaligned[%0d]: err=%b stall=%0d bus_cycles=%0d, need 1 1 0",
                                   i, e, n, valid_cycles - v0);
            end
        end
    endtask

    task automatic test_aw_delay();
        int n; logic e, lv; logic [31:0] d;
        logic [2:0] exp_t [7] = '{3'b000, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        set_delays(4, 0, 0, 0, 0);
        access(1'b0, 1'b1, 32'h104, 32'h01020304, 2'd2, 1'b0, n, e, lv, d);
        ref_store(32'h104, 2'd2, 32'h01020304);
        checks++;
        if (n !== 7 || e !== 1'b0) begin
            errors++; $display("FAIL aw_delay_len: stall=%0d err=%b, need 7 0", n, e);
        end
        for (int i = 0; i < 7 && i < trace_q.size(); i++) begin
            checks++;
            if (trace_q[i] !== exp_t[i]) begin
                errors++; $display("FAIL aw_delay_trace[%0d]: aw,w,b=%b, need %b", i, trace_q[i], exp_t[i]);
            end
        end
        set_delays(0, 3, 0, 0, 0);
        access(1'b0, 1'b1, 32'h108, 32'hCAFEF00D, 2'd2, 1'b0, n, e, lv, d);
        ref_store(32'h108, 2'd2, 32'hCAFEF00D);
        checks++;
        if (n !== 6 || cap_wdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL w_delay: stall=%0d wdata=%h, need 6 cafef00d", n, cap_wdata);
        end
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_bus_errors();
        int n; logic e, lv; logic [31:0] d;
        r_err = 1'b1;
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, n, e, lv, d);
        r_err = 1'b0;
        checks++;
        if (e !== 1'b1 || d !== 32'h0 || lv !== 1'b1) begin
            errors++; $display("FAIL rresp_err: err=%b data=%h lv=%b, need 1 0 1", e, d, lv);
        end
        b_err = 1'b1;
        access(1'b0, 1'b1, 32'h10C, 32'h11111111, 2'd2, 1'b0, n, e, lv, d);
        b_err = 1'b0;
        checks++;
        if (e !== 1'b1 || lv !== 1'b0 || n !== 3) begin
            errors++; $display("FAIL bresp_err: err=%b lv=%b stall=%0d, need 1 0 3", e, lv, n);
        end
    endtask

    task automatic test_reset_mid_read();
        int n; logic e, lv; logic [31:0] d;
        set_delays(0, 0, 0, 0, 20);
        @(negedge clk);
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_uns = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (m_rready !== 1'b1 || m_arvalid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL rd_data_entry: rready=%b arvalid=%b stall=%b, need 1 0 1",
                               m_rready, m_arvalid, stall);
        end
        @(negedge clk); rst = 1'b1; req_rd = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || stall !== 1'b0 || ld_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_read: arvalid=%b rready=%b stall=%b ld_valid=%b, need 0 0 0 0",
                               m_arvalid, m_rready, stall, ld_valid);
        end
        @(negedge clk); rst = 1'b0;
        set_delays(0, 0, 0, 0, 0);
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, n, e, lv, d);
        checks++;
        if (n !== 3 || d !== ref_load(32'h100, 2'd2, 1'b0) || lv !== 1'b1) begin
            errors++; $display("FAIL after_reset_load: stall=%0d data=%h lv=%b, need 3 %h 1",
                               n, d, lv, ref_load(32'h100, 2'd2, 1'b0));
        end
    endtask

    task automatic test_random();
        int n, v0, exp_n; logic e, lv, rd, uns, bad; logic [31:0] d, addr, wd, exp_d; logic [1:0] size;
        for (int it = 0; it < 80; it++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom_range(0, 3), $urandom_range(0, 2));
            size = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            rd   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            bad  = is_misaligned(addr, size);
            v0   = valid_cycles;
            exp_d = ref_load(addr, size, uns);
            access(rd, !rd, addr, wd, size, uns, n, e, lv, d);
            if (bad) begin
                checks++;
                if (e !== 1'b1 || n !== 1 || lv !== 1'b0 || valid_cycles !== v0) begin
                    errors++; $display("FAIL rnd_misaligned[%0d]: err=%b stall=%0d lv=%b bus=%0d, need 1 1 0 0",
                                       it, e, n, lv, valid_cycles - v0);
                end
            end else if (rd) begin
                exp_n = 3 + ar_dly + r_dly;
                checks++;
                if (d !== exp_d || e !== 1'b0 || lv !== 1'b1 || n !== exp_n) begin
                    errors++; $display("FAIL rnd_load[%0d] a=%h sz=%0d u=%b: data=%h err=%b lv=%b stall=%0d, need %h 0 1 %0d",
                                       it, addr, size, uns, d, e, lv, n, exp_d, exp_n);
                end
            end else begin
                ref_store(addr, size, wd);
                exp_n = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
                checks++;
                if (e !== 1'b0 || lv !== 1'b0 || n !== exp_n) begin
                    errors++; $display("FAIL rnd_store[%0d] a=%h sz=%0d: err=%b lv=%b stall=%0d, need 0 0 %0d",
                                       it, addr, size, e, lv, n, exp_n);
                end
            end
        end
        set_delays(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_misaligned();
        test_aw_delay();
        test_bus_errors();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
